// File: rtl/led_switch_ctrl.sv
// Switch-to-LED gating with per-group synchronised, debounced buttons.
// Four run-time modes: live, toggle-enable, capture and blink.
module led_switch_ctrl #(
    parameter int GROUPS          = 4,
    parameter int GROUP_W         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_CYCLES    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [GROUPS*GROUP_W-1:0] sw,
    input  logic [GROUPS-1:0]         btn,
    input  logic [1:0]                mode,
    output logic [GROUPS*GROUP_W-1:0] led,
    output logic [GROUPS-1:0]         btn_db,
    output logic [GROUPS-1:0]         grp_en
);

    localparam int N  = GROUPS * GROUP_W;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [1:0] MODE_LIVE    = 2'd0;
    localparam logic [1:0] MODE_TOGGLE  = 2'd1;
    localparam logic [1:0] MODE_CAPTURE = 2'd2;
    localparam logic [1:0] MODE_BLINK   = 2'd3;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [GROUPS-1:0]         sync1;
    logic [GROUPS-1:0]         btn_s;
    logic [GROUPS-1:0][CW-1:0] cnt;
    logic [GROUPS-1:0]         db_q;
    logic [GROUPS-1:0]         press;
    logic [N-1:0]              cap;
    logic [N-1:0]              led_nxt;
    logic [BW-1:0]             bcnt;
    logic                      phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            btn_s <= '0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    // Any return to equality before the count completes restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= '0;
            cnt    <= '0;
        end else begin
            for (int g = 0; g < GROUPS; g++) begin
                if (btn_s[g] == btn_db[g]) begin
                    cnt[g] <= '0;
                end else if (cnt[g] == CNT_LAST) begin
                    btn_db[g] <= btn_s[g];
                    cnt[g]    <= '0;
                end else begin
                    cnt[g] <= cnt[g] + CW'(1);
                end
            end
        end
    end

    assign press = btn_db & ~db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q   <= '0;
            grp_en <= '0;
            cap    <= '0;
        end else begin
            db_q   <= btn_db;
            grp_en <= grp_en ^ press;
            for (int g = 0; g < GROUPS; g++) begin
                if (press[g]) begin
                    cap[g*GROUP_W +: GROUP_W] <= sw[g*GROUP_W +: GROUP_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            unique case (mode)
                MODE_LIVE: begin
                    if (btn_db[g])
                        led_nxt[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W];
                end
                MODE_TOGGLE: begin
                    if (grp_en[g])
                        led_nxt[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W];
                end
                MODE_CAPTURE: begin
                    led_nxt[g*GROUP_W +: GROUP_W] = cap[g*GROUP_W +: GROUP_W];
                end
                MODE_BLINK: begin
                    if (grp_en[g] && phase)
                        led_nxt[g*GROUP_W +: GROUP_W] = sw[g*GROUP_W +: GROUP_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= '0;
        else        led <= led_nxt;
    end

endmodule
